gfx256_wbm_arbiter: RTL

// - Shares the single 256-bit texture/bus port of gfx256_wbm_rw between NREQ graphics

---
 rtl/gfx256_pkg.sv | 24 ++
 rtl/gfx256_rr_picker.sv | 40 ++++
 rtl/gfx256_wbm_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gfx256_pkg.sv
// Shared types and widths for the gfx256 texture-bus arbiter.
//   ARB_* states   : arbiter FSM encoding
//   gfx256_cmd_t   : latched downstream command (write flag, address, lane select, data)
package gfx256_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned SEL_W = 32;
  localparam int unsigned DAT_W = 256;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } gfx256_arb_state_t;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] dat;
  } gfx256_cmd_t;

endpackage

// File: rtl/gfx256_rr_picker.sv
// Combinational winner selection among pending clients.
//   pending_i : per-client pending mask
//   ptr_i     : round-robin start index (ignored when rr_en_i=0)
//   rr_en_i   : 1 = first pending at/after ptr_i (wrapping), 0 = lowest pending index
//   grant_o   : one-hot winner (0 when nothing pending)
//   idx_o     : winner index
//   any_o     : at least one client pending
module gfx256_rr_picker #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  pending_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             rr_en_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic        found;
  int unsigned cand;

  // Scan NREQ candidates starting at the pointer; the first pending one wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = |pending_i;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = rr_en_i ? ((32'(ptr_i) + k) % NREQ) : k;
      if (!found && pending_i[IDX_W'(cand)]) begin
        found = 1'b1;
        idx_o = IDX_W'(cand);
      end
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/gfx256_wbm_arbiter.sv
// Shares the single 256-bit texture port between NREQ clients, one transaction at a time.
//   req_rd_i/req_wr_i/req_adr_i/req_sel_i/req_dat_i : per-client level requests + command
//   req_dat_o/req_ack_o                              : read data and one-hot completion pulse
//   read_request_o/write_request_o/texture_*_o       : downstream command (pulse in ISSUE)
//   texture_dat_i/texture_ack_i                      : downstream response
//   grant_o/busy_o/timeout_o                         : status (timeout is sticky until reset)
module gfx256_wbm_arbiter
  import gfx256_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter logic        RR_EN   = 1'b1,
  parameter int unsigned TO_BITS = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_rd_i,
  input  logic [NREQ-1:0]       req_wr_i,
  input  logic [NREQ*ADR_W-1:0] req_adr_i,
  input  logic [NREQ*SEL_W-1:0] req_sel_i,
  input  logic [NREQ*DAT_W-1:0] req_dat_i,
  output logic [DAT_W-1:0]      req_dat_o,
  output logic [NREQ-1:0]       req_ack_o,
  output logic                  read_request_o,
  output logic                  write_request_o,
  output logic [ADR_W-1:0]      texture_addr_o,
  output logic [SEL_W-1:0]      texture_sel_o,
  output logic [DAT_W-1:0]      texture_dat_o,
  input  logic [DAT_W-1:0]      texture_dat_i,
  input  logic                  texture_ack_i,
  output logic [NREQ-1:0]       grant_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  gfx256_arb_state_t  state_q, state_d;
  gfx256_cmd_t        cmd_q, cmd_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [DAT_W-1:0]   rdat_q, rdat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [TO_BITS-1:0] cnt_q, cnt_d;
  logic               rd_req_q, rd_req_d;
  logic               wr_req_q, wr_req_d;
  logic               busy_q, busy_d;
  logic               to_q, to_d;

  logic [NREQ-1:0]    pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [ADR_W-1:0]   adr_arr [NREQ];
  logic [SEL_W-1:0]   sel_arr [NREQ];
  logic [DAT_W-1:0]   dat_arr [NREQ];

  // Per-client views of the flattened command buses.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign adr_arr[i] = req_adr_i[i*ADR_W +: ADR_W];
    assign sel_arr[i] = req_sel_i[i*SEL_W +: SEL_W];
    assign dat_arr[i] = req_dat_i[i*DAT_W +: DAT_W];
  end

  gfx256_rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .pending_i (req_rd_i | req_wr_i),
    .ptr_i     (ptr_q),
    .rr_en_i   (RR_EN),
    .grant_o   (pick_grant),
    .idx_o     (pick_idx),
    .any_o     (pick_any)
  );

  // Next-state and command/status logic.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    grant_d  = grant_q;
    ack_d    = '0;
    rdat_d   = rdat_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rd_req_d = 1'b0;
    wr_req_d = 1'b0;
    to_d     = to_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          // rd+wr together on the winner is a write
          cmd_d.we  = req_wr_i[pick_idx];
          cmd_d.adr = adr_arr[pick_idx];
          cmd_d.sel = sel_arr[pick_idx];
          cmd_d.dat = dat_arr[pick_idx];
          idx_d     = pick_idx;
          grant_d   = pick_grant;
          wr_req_d  = req_wr_i[pick_idx];
          rd_req_d  = !req_wr_i[pick_idx];
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (texture_ack_i) begin
          rdat_d  = texture_dat_i;
          ack_d   = grant_q;
          state_d = ARB_DONE;
        end else if (!(&cnt_q)) begin
          // Downstream cycle stays open, so saturation only flags, never aborts.
          cnt_d = cnt_q + TO_BITS'(1);
          if (&cnt_d) to_d = 1'b1;
        end
      end
      ARB_DONE: begin
        ptr_d   = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
        grant_d = '0;
        cnt_d   = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      cmd_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      rdat_q   <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
    end
  end

  assign req_dat_o       = rdat_q;
  assign req_ack_o       = ack_q;
  assign read_request_o  = rd_req_q;
  assign write_request_o = wr_req_q;
  assign texture_addr_o  = cmd_q.adr;
  assign texture_sel_o   = cmd_q.sel;
  assign texture_dat_o   = cmd_q.dat;
  assign grant_o         = grant_q;
  assign busy_o          = busy_q;
  assign timeout_o       = to_q;

endmodule
